// File: rtl/timer_arbiter_pkg.sv
// Shared definitions for the two-requester interval timer arbiter.
package timer_arbiter_pkg;

    localparam int DEFAULT_WIDTH = 4;
    localparam int NUM_REQ       = 2;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/timer_arbiter_interval_counter.sv
// Interval up-counter: cleared, enabled and compared against a limit by the owning FSM.
module interval_counter
    import timer_arbiter_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             enable,
    input  logic [WIDTH-1:0] limit,
    output logic [WIDTH-1:0] count,
    output logic             match
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + WIDTH'(1);
        end
    end

    assign match = (count == limit);

endmodule

// File: rtl/timer_arbiter.sv
// Round-robin arbiter granting one of two requesters a timed interval of len+1 cycles.
//   state | meaning
//   IDLE  | no grant; any request is arbitrated on the next edge
//   RUN   | one requester granted; count advances toward len_q unless held
module timer_arbiter
    import timer_arbiter_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
    input  logic [WIDTH-1:0]   len0,
    input  logic [WIDTH-1:0]   len1,
    input  logic               hold,
    output logic [NUM_REQ-1:0] gnt,
    output logic [NUM_REQ-1:0] done,
    output logic               busy,
    output logic [WIDTH-1:0]   count
);

    state_t           state;
    logic [WIDTH-1:0] len_q;
    logic             ptr;
    logic             win;
    logic [WIDTH-1:0] win_len;
    logic             match;
    logic             finish;
    logic             clear;
    logic             enable;

    // ptr names the requester that wins a tie
    always_comb begin
        win = 1'b0;
        case (req)
            2'b01:   win = 1'b0;
            2'b10:   win = 1'b1;
            2'b11:   win = ptr;
            default: win = 1'b0;
        endcase
    end

    assign win_len = win ? len1 : len0;
    assign finish  = (state == RUN) && match && !hold;
    assign done    = finish ? gnt : '0;
    assign busy    = (state == RUN);
    assign clear   = (state == IDLE) || finish;
    assign enable  = (state == RUN) && !hold && !match;

    interval_counter #(.WIDTH(WIDTH)) u_counter (
        .clk    (clk),
        .reset  (reset),
        .clear  (clear),
        .enable (enable),
        .limit  (len_q),
        .count  (count),
        .match  (match)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            gnt   <= '0;
            len_q <= '0;
            ptr   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req != '0) begin
                        state <= RUN;
                        gnt   <= win ? 2'b10 : 2'b01;
                        len_q <= win_len;
                    end
                end
                RUN: begin
                    if (finish) begin
                        state <= IDLE;
                        gnt   <= '0;
                        ptr   <= gnt[0];
                    end
                end
                default: begin
                    state <= IDLE;
                    gnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_timer_arbiter.sv
// Self-checking bench for timer_arbiter: fixed vector table, corner sequences, random vs model.
module tb_timer_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] req;
    logic [3:0] len0;
    logic [3:0] len1;
    logic       hold;
    logic [1:0] gnt;
    logic [1:0] done;
    logic       busy;
    logic [3:0] count;

    timer_arbiter #(.WIDTH(4)) dut (
        .clk   (clk),
        .reset (reset),
        .req   (req),
        .len0  (len0),
        .len1  (len1),
        .hold  (hold),
        .gnt   (gnt),
        .done  (done),
        .busy  (busy),
        .count (count)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int gnt_seen = 0;

    // reference model: who owns the interval, how far it has run, its length, who wins a tie
    int m_owner;
    int m_cnt;
    int m_len;
    int m_ptr;

    typedef struct {
        logic [1:0] r;
        logic [3:0] a;
        logic [3:0] b;
        logic       h;
        logic [1:0] g;
        logic [1:0] d;
        logic [3:0] c;
        logic       bz;
    } vec_t;

    vec_t tbl[20];

    int   hold_exp_c[9];
    logic hold_pat[9];

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_cnt   = 0;
        m_len   = 0;
        m_ptr   = 0;
    endtask

    task automatic check_model();
        int eg;
        int ed;
        eg = (m_owner < 0) ? 0 : (1 << m_owner);
        ed = (m_owner >= 0 && m_cnt == m_len && !hold) ? eg : 0;
        chk("model.gnt",   8'(gnt),   8'(eg));
        chk("model.done",  8'(done),  8'(ed));
        chk("model.count", 8'(count), 8'(m_cnt));
        chk("model.busy",  8'(busy),  8'(m_owner >= 0));
    endtask

    task automatic model_step();
        int w;
        if (m_owner < 0) begin
            if (req != 2'b00) begin
                if (req == 2'b11) w = m_ptr;
                else              w = (req == 2'b10) ? 1 : 0;
                m_owner = w;
                m_len   = (w == 1) ? int'(len1) : int'(len0);
                m_cnt   = 0;
            end
        end else if (m_cnt == m_len && !hold) begin
            m_ptr   = 1 - m_owner;
            m_owner = -1;
            m_cnt   = 0;
        end else if (!hold) begin
            m_cnt++;
        end
    endtask

    // called shortly after a rising edge; returns shortly after the next one
    task automatic step(input logic [1:0] r, input logic [3:0] a, input logic [3:0] b,
                        input logic h, input bit use_exp, input logic [1:0] eg,
                        input logic [1:0] ed, input logic [3:0] ec, input logic eb,
                        input string tag);
        req  = r;
        len0 = a;
        len1 = b;
        hold = h;
        @(negedge clk);
        check_model();
        if (gnt != 2'b00) gnt_seen++;
        if (use_exp) begin
            chk({tag, ".gnt"},   8'(gnt),   8'(eg));
            chk({tag, ".done"},  8'(done),  8'(ed));
            chk({tag, ".count"}, 8'(count), 8'(ec));
            chk({tag, ".busy"},  8'(busy),  8'(eb));
        end
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic run(input logic [1:0] r, input logic [3:0] a, input logic [3:0] b, input logic h);
        step(r, a, b, h, 1'b0, 2'b00, 2'b00, 4'd0, 1'b0, "run");
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req   = 2'b00;
        hold  = 1'b0;
        model_reset();
        #1;
        chk("reset.gnt",   8'(gnt),   8'h00);
        chk("reset.done",  8'(done),  8'h00);
        chk("reset.count", 8'(count), 8'h00);
        chk("reset.busy",  8'(busy),  8'h00);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        req   = 2'b00;
        len0  = 4'd0;
        len1  = 4'd0;
        hold  = 1'b0;

        tbl[0]  = '{2'b01, 4'd3, 4'd0, 1'b0, 2'b00, 2'b00, 4'd0, 1'b0};
        tbl[1]  = '{2'b01, 4'd3, 4'd0, 1'b0, 2'b01, 2'b00, 4'd0, 1'b1};
        tbl[2]  = '{2'b01, 4'd3, 4'd0, 1'b0, 2'b01, 2'b00, 4'd1, 1'b1};
        tbl[3]  = '{2'b01, 4'd3, 4'd0, 1'b0, 2'b01, 2'b00, 4'd2, 1'b1};
        tbl[4]  = '{2'b01, 4'd3, 4'd0, 1'b0, 2'b01, 2'b01, 4'd3, 1'b1};
        tbl[5]  = '{2'b00, 4'd3, 4'd0, 1'b0, 2'b00, 2'b00, 4'd0, 1'b0};
        tbl[6]  = '{2'b10, 4'd0, 4'd0, 1'b0, 2'b00, 2'b00, 4'd0, 1'b0};
        tbl[7]  = '{2'b10, 4'd0, 4'd0, 1'b0, 2'b10, 2'b10, 4'd0, 1'b1};
        tbl[8]  = '{2'b11, 4'd2, 4'd1, 1'b0, 2'b00, 2'b00, 4'd0, 1'b0};
        tbl[9]  = '{2'b11, 4'd2, 4'd1, 1'b0, 2'b01, 2'b00, 4'd0, 1'b1};
        tbl[10] = '{2'b11, 4'd2, 4'd1, 1'b0, 2'b01, 2'b00, 4'd1, 1'b1};
        tbl[11] = '{2'b11, 4'd2, 4'd1, 1'b0, 2'b01, 2'b01, 4'd2, 1'b1};
        tbl[12] = '{2'b11, 4'd2, 4'd1, 1'b0, 2'b00, 2'b00, 4'd0, 1'b0};
        tbl[13] = '{2'b11, 4'd2, 4'd1, 1'b0, 2'b10, 2'b00, 4'd0, 1'b1};
        tbl[14] = '{2'b11, 4'd2, 4'd1, 1'b0, 2'b10, 2'b10, 4'd1, 1'b1};
        tbl[15] = '{2'b11, 4'd2, 4'd1, 1'b0, 2'b00, 2'b00, 4'd0, 1'b0};
        tbl[16] = '{2'b11, 4'd2, 4'd1, 1'b0, 2'b01, 2'b00, 4'd0, 1'b1};
        tbl[17] = '{2'b11, 4'd2, 4'd1, 1'b0, 2'b01, 2'b00, 4'd1, 1'b1};
        tbl[18] = '{2'b11, 4'd2, 4'd1, 1'b0, 2'b01, 2'b01, 4'd2, 1'b1};
        tbl[19] = '{2'b00, 4'd2, 4'd1, 1'b0, 2'b00, 2'b00, 4'd0, 1'b0};

        hold_exp_c = '{0, 1, 2, 2, 2, 2, 3, 4, 5};
        hold_pat   = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

        do_reset();

        // single, zero-length and alternating grants
        for (int i = 0; i < 20; i++) begin
            step(tbl[i].r, tbl[i].a, tbl[i].b, tbl[i].h, 1'b1,
                 tbl[i].g, tbl[i].d, tbl[i].c, tbl[i].bz, $sformatf("tbl[%0d]", i));
        end

        // hold freezes the count for three cycles mid-interval
        do_reset();
        step(2'b01, 4'd5, 4'd0, 1'b0, 1'b1, 2'b00, 2'b00, 4'd0, 1'b0, "hold.idle");
        gnt_seen = 0;
        for (int i = 0; i < 9; i++) begin
            step(2'b01, 4'd5, 4'd0, hold_pat[i], 1'b1, 2'b01, (i == 8) ? 2'b01 : 2'b00,
                 4'(hold_exp_c[i]), 1'b1, $sformatf("hold[%0d]", i));
        end
        step(2'b00, 4'd5, 4'd0, 1'b0, 1'b1, 2'b00, 2'b00, 4'd0, 1'b0, "hold.after");
        chk("hold.gnt_cycles", 8'(gnt_seen), 8'd9);

        // asynchronous reset mid-interval, then requester 0 wins a tie
        do_reset();
        for (int i = 0; i < 5; i++) run(2'b01, 4'd15, 4'd0, 1'b0);
        chk("arst.count_before", 8'(count), 8'd4);
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        chk("arst.gnt",   8'(gnt),   8'h00);
        chk("arst.count", 8'(count), 8'h00);
        chk("arst.busy",  8'(busy),  8'h00);
        chk("arst.done",  8'(done),  8'h00);
        @(posedge clk);
        #1;
        reset = 1'b0;
        run(2'b11, 4'd2, 4'd2, 1'b0);
        chk("arst.first_gnt", 8'(gnt), 8'h01);

        // length change and request drop during RUN do not disturb the interval
        do_reset();
        step(2'b01, 4'd3, 4'd0, 1'b0, 1'b1, 2'b00, 2'b00, 4'd0, 1'b0, "chg.idle");
        step(2'b01, 4'd3, 4'd0, 1'b0, 1'b1, 2'b01, 2'b00, 4'd0, 1'b1, "chg.c0");
        step(2'b00, 4'd9, 4'd9, 1'b0, 1'b1, 2'b01, 2'b00, 4'd1, 1'b1, "chg.c1");
        step(2'b00, 4'd9, 4'd9, 1'b0, 1'b1, 2'b01, 2'b00, 4'd2, 1'b1, "chg.c2");
        step(2'b00, 4'd9, 4'd9, 1'b0, 1'b1, 2'b01, 2'b01, 4'd3, 1'b1, "chg.c3");
        step(2'b00, 4'd9, 4'd9, 1'b0, 1'b1, 2'b00, 2'b00, 4'd0, 1'b0, "chg.idle2");

        // random traffic against the model
        do_reset();
        for (int i = 0; i < 800; i++) begin
            logic [3:0] a;
            logic [3:0] b;
            if ($urandom_range(0, 199) == 0) do_reset();
            a = ($urandom_range(0, 9) == 0) ? 4'd15 : 4'($urandom_range(0, 5));
            b = ($urandom_range(0, 9) == 0) ? 4'd15 : 4'($urandom_range(0, 5));
            run(2'($urandom_range(0, 3)), a, b, ($urandom_range(0, 3) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
